// File: rtl/rpc_config_path_pkg.sv
// Shared configuration types for the RPC DRAM controller config path.
// Holds the refresh timer register layout, its default setting and FSM states.
// Pure declarations; no logic, no latency.
package rpc_config_path_pkg;

  localparam int unsigned REFRESH_PEND_WIDTH     = 4;
  localparam int unsigned REFRESH_INTERVAL_WIDTH = 16;

  typedef struct packed {
    logic                              mode;      // 1: use fields, 0: use default
    logic [REFRESH_INTERVAL_WIDTH-1:0] interval;  // refresh period in units of 128 cycles
    logic [REFRESH_PEND_WIDTH-1:0]     max_pend;  // postponable credit limit
  } refresh_timer_cfg_reg_t;

  localparam refresh_timer_cfg_reg_t REFRESH_TIMER_DEFAULT_SETTING = '{
    mode:     1'b1,
    interval: 16'd30,
    max_pend: 4'd8
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } refresh_timer_state_e;

endpackage

// File: rtl/counter.sv
// Generic up/down counter with synchronous clear and load, plus overflow flag.
// Latency: q_o reflects clear/load/count one cycle after the request.
// Backpressure: none; counts whenever en_i is high.
module counter #(
  parameter int unsigned WIDTH           = 4,
  parameter bit          STICKY_OVERFLOW = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_ovf;
  logic [WIDTH:0]   w_cnt_next;

  // Next count with one extra bit that catches wrap in either direction.
  always_comb begin
    w_cnt_next = {1'b0, r_cnt};
    if (clear_i) begin
      w_cnt_next = '0;
    end else if (load_i) begin
      w_cnt_next = {1'b0, d_i};
    end else if (en_i) begin
      w_cnt_next = down_i ? ({1'b0, r_cnt} - (WIDTH+1)'(1))
                          : ({1'b0, r_cnt} + (WIDTH+1)'(1));
    end
  end

  // Count register and overflow flag; clear also drops a sticky overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next[WIDTH-1:0];
      if (clear_i) begin
        r_ovf <= 1'b0;
      end else if (STICKY_OVERFLOW) begin
        r_ovf <= r_ovf | w_cnt_next[WIDTH];
      end else begin
        r_ovf <= w_cnt_next[WIDTH];
      end
    end
  end

  assign q_o        = r_cnt;
  assign overflow_o = r_ovf;

endmodule

// File: rtl/refresh_timer.sv
// Periodic refresh request generator: armed by start_i, ticks every interval<<7 cycles.
// Latency: start_i at t -> active_o at t+1; request visible the cycle after each tick.
// Backpressure: credits queue up to the limit; a tick at the limit is dropped and flags overrun_o.
// Macro RPC_REFRESH_POSTPONE_EN: limit from max_pend (postponement); otherwise limit is 1.
module refresh_timer
  import rpc_config_path_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned PEND_WIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_config_i,
  input  refresh_timer_cfg_reg_t config_i,
  input  logic                   start_i,
  output logic                   refresh_valid_o,
  input  logic                   refresh_ready_i,
  output logic                   urgent_o,
  output logic [PEND_WIDTH-1:0]  pending_o,
  output logic                   overrun_o,
  output logic                   active_o
);

  refresh_timer_state_e   r_state, w_state_d;
  refresh_timer_cfg_reg_t r_shadow, r_active, w_apply_cfg;
  logic                   r_shadow_vld;
  logic                   w_apply;

  logic [CNT_WIDTH-1:0]   w_cnt, w_ceiling;
  logic                   w_ivl_zero, w_tick, w_cnt_en, w_cnt_clr;
  logic                   w_unused_ovf, w_unused_cfg;

  logic [PEND_WIDTH-1:0]  r_pend, w_limit;
  logic                   r_overrun, w_hs;

  // Interval arithmetic: a zero interval parks the counter at 0 and suppresses ticks.
  assign w_ceiling  = CNT_WIDTH'(r_active.interval) << 7;
  assign w_ivl_zero = (r_active.interval == '0);
  assign w_tick     = (r_state == RUN) && !w_ivl_zero && (w_cnt == w_ceiling - CNT_WIDTH'(1));
  assign w_cnt_en   = (r_state == RUN) && !w_ivl_zero;
  assign w_cnt_clr  = (r_state != RUN) || w_tick || w_ivl_zero;

  counter #(
    .WIDTH          (CNT_WIDTH),
    .STICKY_OVERFLOW(1'b0)
  ) u_interval_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (w_cnt_clr),
    .en_i      (w_cnt_en),
    .load_i    (1'b0),
    .down_i    (1'b0),
    .d_i       ('0),
    .q_o       (w_cnt),
    .overflow_o(w_unused_ovf)
  );

`ifdef RPC_REFRESH_POSTPONE_EN
  localparam int unsigned PEND_MAX = (1 << PEND_WIDTH) - 1;
  logic [31:0] w_lim_raw;
  assign w_lim_raw    = (r_active.max_pend == '0) ? 32'd1 : 32'(r_active.max_pend);
  assign w_limit      = (w_lim_raw > PEND_MAX) ? PEND_WIDTH'(PEND_MAX) : PEND_WIDTH'(w_lim_raw);
  assign w_unused_cfg = r_active.mode;
`else
  assign w_limit      = PEND_WIDTH'(1);
  assign w_unused_cfg = ^{r_active.mode, r_active.max_pend};
`endif

  // Next state and config-apply decision; mode=0 or no shadow selects the default setting.
  always_comb begin
    w_state_d   = r_state;
    w_apply     = 1'b0;
    w_apply_cfg = REFRESH_TIMER_DEFAULT_SETTING;
    if (r_shadow_vld && r_shadow.mode) begin
      w_apply_cfg = r_shadow;
    end
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_d = RUN;
          w_apply   = 1'b1;
        end
      end
      RUN: begin
        w_apply = w_tick && r_shadow_vld;
      end
    endcase
  end

  // State register; RUN is only left through reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Shadow capture and active-config update; a fresh load outranks the apply-clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
      r_active     <= '0;
    end else begin
      if (load_config_i) begin
        r_shadow     <= config_i;
        r_shadow_vld <= 1'b1;
      end else if (w_apply) begin
        r_shadow_vld <= 1'b0;
      end
      if (w_apply) begin
        r_active <= w_apply_cfg;
      end
    end
  end

  assign w_hs = (r_pend != '0) && refresh_ready_i;

  // Credit accounting: tick adds, handshake subtracts, tick at the limit is lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_state == IDLE) begin
        r_pend <= '0;
      end else if (w_tick && !w_hs) begin
        if (r_pend >= w_limit) begin
          r_overrun <= 1'b1;
        end else begin
          r_pend <= r_pend + 1'b1;
        end
      end else if (w_hs && !w_tick) begin
        r_pend <= r_pend - 1'b1;
      end
    end
  end

  assign refresh_valid_o = (r_pend != '0);
  assign urgent_o        = (r_pend == w_limit);
  assign pending_o       = r_pend;
  assign overrun_o       = r_overrun;
  assign active_o        = (r_state == RUN);

endmodule
